pipe_dmem_arbiter: RTL

- Shares the single-port data RAM of the pipelined computer between two requesters: the pipeline MEM stage (requester 0) and a debug/loader port (requester 1).
- The CPU has priority, because its access must finish in the cycle it is presented.
- The debug port gets guaranteed forward progress by stealing one RAM cycle after bounded contention. It stalls the pipeline for that cycle (stall semantics match wpcir hold).
- Sits between the EXE/MEM register outputs and the data RAM, which is clocked on mem_clock, i.e. read data is valid within the same clock cycle.

---
 rtl/pipe_arb_pkg.sv | 6 +
 rtl/pipe_arb_starve_ctr.sv | 19 +
 rtl/pipe_dmem_arbiter.sv | 70 +++++++
 3 files changed

// File: rtl/pipe_arb_pkg.sv
// pipe_arb_pkg: shared state encoding, data width and default contention limit for the dmem arbiter
package pipe_arb_pkg;
  typedef enum logic [1:0] {CPU_OWN = 2'd0, DBG_SLOT = 2'd1, LOCK = 2'd2} arb_state_t;
  localparam int DATA_W = 32;
  localparam int STARVE_LIMIT_DEF = 4;
endpackage

// File: rtl/pipe_arb_starve_ctr.sv
// pipe_arb_starve_ctr: saturating 8-bit contention counter with clear and terminal-count flag
module pipe_arb_starve_ctr
  import pipe_arb_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clock,
  input  logic resetn,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_tc
);
  logic [7:0] r_cnt;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
  assign o_tc = r_cnt == 8'(LIMIT - 1);
endmodule

// File: rtl/pipe_dmem_arbiter.sv
// pipe_dmem_arbiter: shares the data RAM between the MEM stage and a debug port, stealing a stall slot after contention.
// Optional debug bus lock (dbg_lock input, LOCK state) enabled by PIPE_DMEM_ARB_LOCK_EN.
module pipe_dmem_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clock,
  input  logic              resetn,
`ifdef PIPE_DMEM_ARB_LOCK_EN
  input  logic              dbg_lock,
`endif
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [15:0]       dbg_grant_cnt
);
  arb_state_t  r_state, w_next;
  logic        w_contend, w_tc, w_dbg_own, w_unused_addr;
  logic [15:0] r_grant;
  assign w_contend = (r_state == CPU_OWN) && cpu_req && dbg_req;
  // Debug owns the RAM in any stolen/locked state, or whenever the CPU is idle
  assign w_dbg_own = (r_state != CPU_OWN) || !cpu_req;
  assign cpu_stall = r_state != CPU_OWN;
  assign dbg_ack   = resetn && dbg_req && w_dbg_own;
  assign ram_we    = resetn && (w_dbg_own ? (dbg_we && dbg_req) : cpu_we);
  assign ram_addr  = w_dbg_own ? dbg_addr : cpu_addr[ADDR_W+1:2];
  assign ram_wdata = w_dbg_own ? dbg_wdata : cpu_wdata;
  assign cpu_rdata = ram_rdata;
  assign dbg_rdata = ram_rdata;
  assign dbg_grant_cnt = r_grant;
  assign w_unused_addr = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};
  pipe_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clock (clock),
    .resetn(resetn),
    .i_inc (w_contend),
    .i_clr (!w_contend || w_tc),
    .o_tc  (w_tc)
  );
  always_comb begin
`ifdef PIPE_DMEM_ARB_LOCK_EN
    w_next = ((dbg_ack || r_state == LOCK) && dbg_lock) ? LOCK :
             (w_contend && w_tc) ? DBG_SLOT : CPU_OWN;
`else
    w_next = (w_contend && w_tc) ? DBG_SLOT : CPU_OWN;
`endif
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_state <= CPU_OWN;
      r_grant <= '0;
    end else begin
      r_state <= w_next;
      if (dbg_ack) r_grant <= r_grant + 16'd1;
    end
endmodule
